// File: rtl/riscv_pkg.sv
// Shared types for the instruction prefetch path.
//   PrefetchState : bus-side FSM states of the prefetcher
//   parcel_t      : one 16-bit instruction parcel
//   isInsn32      : true when a parcel starts a 32-bit (non-compressed) instruction; the core
//                   decoder uses the same test
package riscv_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DISCARD
  } PrefetchState;

  typedef logic [15:0] parcel_t;

  function automatic logic isInsn32(input parcel_t parcel);
    return parcel[1:0] == 2'b11;
  endfunction

endpackage

// File: rtl/riscv_parcel_fifo.sv
// Circular buffer of 16-bit instruction parcels.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset (clears storage)
//   flush               drop every queued parcel (pointers and count cleared)
//   push_count          0/1/2 parcels to append; push_lo goes in first, then push_hi
//   pop_count           0/1/2 parcels to remove from the head
//   head0, head1        oldest and second-oldest parcel
//   count               parcels currently held (0..DEPTH)
// The caller guarantees no overflow and no pop beyond count.
module riscv_parcel_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [1:0]               push_count,
  input  parcel_t                  push_lo,
  input  parcel_t                  push_hi,
  input  logic [1:0]               pop_count,
  output parcel_t                  head0,
  output parcel_t                  head1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  parcel_t           storage [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr_next1;
  logic [PTR_W-1:0]  wr_ptr_next1;

  assign rd_ptr_next1 = rd_ptr + 1'b1;
  assign wr_ptr_next1 = wr_ptr + 1'b1;
  assign head0 = storage[rd_ptr];
  assign head1 = storage[rd_ptr_next1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        storage[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_count != 2'd0) begin
        storage[wr_ptr] <= push_lo;
      end
      if (push_count == 2'd2) begin
        storage[wr_ptr_next1] <= push_hi;
      end
      // Depth is a power of two, so pointers wrap by natural overflow.
      wr_ptr <= wr_ptr + PTR_W'(push_count);
      rd_ptr <= rd_ptr + PTR_W'(pop_count);
      count  <= count + CNT_W'(push_count) - CNT_W'(pop_count);
    end
  end

endmodule

// File: rtl/riscv_insn_prefetcher.sv
// Instruction prefetch unit: streams 32-bit bus words into a parcel queue and presents one
// aligned instruction per cycle to decode over a valid/accept handshake.
// Ports:
//   clock, reset                  rising-edge clock, asynchronous active-high reset
//   memAddress, memStrobe         word fetch request; strobe held until memReady
//   memDataRead, memReady         returned word (little-endian) and access-complete
//   insnValid, insnCode           presented instruction (compressed code in [15:0])
//   insnIsCompressed, insnPc      compressed flag and halfword PC of presented instruction
//   insnAccept                    decode consumes the presented instruction
//   redirectValid, redirectPc     load a new halfword PC and flush the queue
// Build option: define RISCV_PREFETCH_RVC_EN for compressed-instruction support. Without it every
// instruction is 32-bit, PCs are kept even and whole words are always enqueued.
module riscv_insn_prefetcher
  import riscv_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE     = 15,
  parameter int unsigned QUEUE_PARCELS    = 4,
  parameter int unsigned RESET_PC_ADDRESS = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic [ADDRESS_SIZE-1:0] memAddress,
  output logic                    memStrobe,
  input  logic [31:0]             memDataRead,
  input  logic                    memReady,
  output logic                    insnValid,
  output logic [31:0]             insnCode,
  output logic                    insnIsCompressed,
  output logic [ADDRESS_SIZE:0]   insnPc,
  input  logic                    insnAccept,
  input  logic                    redirectValid,
  input  logic [ADDRESS_SIZE:0]   redirectPc
);

  localparam int unsigned PC_W  = ADDRESS_SIZE + 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_PARCELS) + 1;

`ifdef RISCV_PREFETCH_RVC_EN
  localparam logic RVC = 1'b1;
`else
  localparam logic RVC = 1'b0;
`endif

  // Without compressed support PCs are halfword-even, so bit 0 is masked everywhere.
  localparam logic [PC_W-1:0]  PC_MASK  = RVC ? {PC_W{1'b1}} : {{ADDRESS_SIZE{1'b1}}, 1'b0};
  localparam logic [PC_W-1:0]  RESET_PC = PC_W'(RESET_PC_ADDRESS >> 1) & PC_MASK;
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(QUEUE_PARCELS);

  PrefetchState     state;
  logic [PC_W-1:0]  fetchPc;

  parcel_t          head0;
  parcel_t          head1;
  logic [CNT_W-1:0] count;
  logic             head_is32;
  logic             accept_fire;
  logic             fetch_done;
  logic             upper_only;
  logic             room;
  logic [1:0]       push_count;
  logic [1:0]       pop_count;
  parcel_t          push_lo;
  logic [PC_W-1:0]  insn_step;
  logic [PC_W-1:0]  fetch_step;

  always_comb begin
    head_is32        = RVC ? isInsn32(head0) : 1'b1;
    insnValid        = head_is32 ? (count >= CNT_W'(2)) : (count != '0);
    insnIsCompressed = (count != '0) && !head_is32;
    insnCode         = head_is32 ? {head1, head0} : {16'h0000, head0};

    accept_fire = insnAccept && insnValid && !redirectValid;
    pop_count   = accept_fire ? (head_is32 ? 2'd2 : 2'd1) : 2'd0;
    insn_step   = head_is32 ? PC_W'(2) : PC_W'(1);

    // An odd fetch PC only wants the upper half of its word.
    upper_only = RVC && fetchPc[0];
    fetch_done = (state == S_FETCH) && memReady && !redirectValid;
    push_count = fetch_done ? (upper_only ? 2'd1 : 2'd2) : 2'd0;
    push_lo    = upper_only ? memDataRead[31:16] : memDataRead[15:0];
    fetch_step = upper_only ? PC_W'(1) : PC_W'(2);

    // Count only shrinks while idle, so judging room from the current count is safe.
    room = (count <= FULL - CNT_W'(2)) || (upper_only && (count <= FULL - CNT_W'(1)));
  end

  riscv_parcel_fifo #(
    .DEPTH (QUEUE_PARCELS)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirectValid),
    .push_count (push_count),
    .push_lo    (push_lo),
    .push_hi    (memDataRead[31:16]),
    .pop_count  (pop_count),
    .head0      (head0),
    .head1      (head1),
    .count      (count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      fetchPc    <= RESET_PC;
      insnPc     <= RESET_PC;
      memAddress <= RESET_PC[PC_W-1:1];
      memStrobe  <= 1'b0;
    end else begin
      if (accept_fire) begin
        insnPc <= insnPc + insn_step;
      end
      unique case (state)
        S_IDLE: begin
          if (!redirectValid && room) begin
            state      <= S_FETCH;
            memAddress <= fetchPc[PC_W-1:1];
            memStrobe  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (memReady) begin
            // Completion coinciding with a redirect is simply dropped.
            memStrobe <= 1'b0;
            state     <= S_IDLE;
            if (!redirectValid) begin
              fetchPc <= fetchPc + fetch_step;
            end
          end else if (redirectValid) begin
            state <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (memReady) begin
            memStrobe <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (redirectValid) begin
        fetchPc <= redirectPc & PC_MASK;
        insnPc  <= redirectPc & PC_MASK;
      end
    end
  end

endmodule

// File: tb/tb_riscv_insn_prefetcher.sv
// Self-checking bench for riscv_insn_prefetcher. Expected instructions come from decoding the
// bench's memory image directly at the expected PC; a bus responder with random latency serves
// fetches and checks the strobe protocol.
module tb_riscv_insn_prefetcher;

  localparam int unsigned AS = 6;
  localparam int unsigned QP = 4;

`ifdef RISCV_PREFETCH_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AS-1:0] memAddress;
  logic          memStrobe;
  logic [31:0]   memDataRead = '0;
  logic          memReady = 1'b0;
  logic          insnValid;
  logic [31:0]   insnCode;
  logic          insnIsCompressed;
  logic [AS:0]   insnPc;
  logic          insnAccept = 1'b0;
  logic          redirectValid = 1'b0;
  logic [AS:0]   redirectPc = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0]   mem [64];
  int unsigned   dly_min = 0;
  int unsigned   dly_max = 0;
  int unsigned   ready_cnt = 0;
  logic [AS-1:0] start_addr_q [$];
  int            snap_q;
  int unsigned   snap_ready;

  riscv_insn_prefetcher #(
    .ADDRESS_SIZE     (AS),
    .QUEUE_PARCELS    (QP),
    .RESET_PC_ADDRESS (0)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .memAddress       (memAddress),
    .memStrobe        (memStrobe),
    .memDataRead      (memDataRead),
    .memReady         (memReady),
    .insnValid        (insnValid),
    .insnCode         (insnCode),
    .insnIsCompressed (insnIsCompressed),
    .insnPc           (insnPc),
    .insnAccept       (insnAccept),
    .redirectValid    (redirectValid),
    .redirectPc       (redirectPc)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic logic [AS:0] pc_norm(input logic [AS:0] p);
    return RVC ? p : {p[AS:1], 1'b0};
  endfunction

  function automatic logic [15:0] hw(input logic [AS:0] p);
    logic [31:0] w;
    w = mem[p[AS:1]];
    return p[0] ? w[31:16] : w[15:0];
  endfunction

  function automatic void model_insn(input logic [AS:0] pc, output logic [31:0] code,
                                     output logic comp, output logic [AS:0] nxt);
    logic [15:0] lo;
    lo = hw(pc);
    if (RVC && lo[1:0] != 2'b11) begin
      code = {16'h0000, lo};
      comp = 1'b1;
      nxt  = pc + 7'd1;
    end else begin
      code = {hw(pc + 7'd1), lo};
      comp = 1'b0;
      nxt  = pc + 7'd2;
    end
  endfunction

  // ---------------- bus responder ----------------
  bit            busy = 1'b0;
  int unsigned   wait_left = 0;
  logic [AS-1:0] busy_addr = '0;

  always @(negedge clock) begin
    if (reset) begin
      memReady = 1'b0;
      busy = 1'b0;
    end else if (memReady) begin
      memReady = 1'b0;
      busy = 1'b0;
      checks++;
      if (memStrobe !== 1'b0) begin
        errors++;
        $display("FAIL strobe_gap: memStrobe %b after completion, required 0", memStrobe);
      end
    end else if (memStrobe) begin
      if (!busy) begin
        busy = 1'b1;
        busy_addr = memAddress;
        start_addr_q.push_back(memAddress);
        wait_left = $urandom_range(dly_max, dly_min);
      end
      if (wait_left == 0) begin
        checks++;
        if (memAddress !== busy_addr) begin
          errors++;
          $display("FAIL addr_stable: memAddress %h, required %h", memAddress, busy_addr);
        end
        memReady = 1'b1;
        memDataRead = mem[memAddress];
        ready_cnt++;
      end else begin
        wait_left--;
      end
    end else if (busy) begin
      busy = 1'b0;
      checks++;
      errors++;
      $display("FAIL strobe_held: memStrobe 0 before memReady, required 1");
    end
  end

  // Stimulus-only helper: pulse a redirect for one cycle, recording bus history first.
  task automatic do_redirect(input logic [AS:0] pc);
    @(negedge clock);
    #1;
    snap_q = start_addr_q.size();
    snap_ready = ready_cnt;
    redirectValid = 1'b1;
    redirectPc = pc;
    @(negedge clock);
    redirectValid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks += 6;
    if (memStrobe !== 1'b0) begin errors++; $display("FAIL rst_strobe: %b, required 0", memStrobe); end
    if (memAddress !== '0) begin errors++; $display("FAIL rst_addr: %h, required 0", memAddress); end
    if (insnValid !== 1'b0) begin errors++; $display("FAIL rst_valid: %b, required 0", insnValid); end
    if (insnCode !== '0) begin errors++; $display("FAIL rst_code: %h, required 0", insnCode); end
    if (insnIsCompressed !== 1'b0) begin
      errors++; $display("FAIL rst_comp: %b, required 0", insnIsCompressed);
    end
    if (insnPc !== '0) begin errors++; $display("FAIL rst_pc: %h, required 0", insnPc); end
    reset = 1'b0;
    @(negedge clock);
    checks += 3;
    if (memStrobe !== 1'b1) begin errors++; $display("FAIL first_strobe: %b, required 1", memStrobe); end
    if (memAddress !== '0) begin errors++; $display("FAIL first_addr: %h, required 0", memAddress); end
    if (insnValid !== 1'b0) begin errors++; $display("FAIL first_valid: %b, required 0", insnValid); end
  endtask

  task automatic test_example();
    logic [AS:0] pc_e, nxt_e;
    logic [31:0] code_e;
    logic        comp_e;
    int got = 0;
    pc_e = '0;
    for (int c = 0; c < 200 && got < 3; c++) begin
      @(negedge clock);
      insnAccept = 1'b1;
      if (insnValid) begin
        model_insn(pc_e, code_e, comp_e, nxt_e);
        checks++;
        if (insnPc !== pc_e || insnCode !== code_e || insnIsCompressed !== comp_e) begin
          errors++;
          $display("FAIL example: pc %h code %h c %b, required pc %h code %h c %b",
                   insnPc, insnCode, insnIsCompressed, pc_e, code_e, comp_e);
        end
        pc_e = nxt_e;
        got++;
      end
    end
    insnAccept = 1'b0;
    checks++;
    if (got != 3) begin errors++; $display("FAIL example_timeout: got %0d insns, required 3", got); end
  endtask

  task automatic test_straddle();
    logic [AS:0] pc_e, nxt_e;
    logic [31:0] code_e;
    logic        comp_e;
    int got = 0;
    mem[1] = 32'h00B3_0001;
    mem[2] = 32'h0000_0513;
    do_redirect(7'd3);
    checks++;
    if (insnValid !== 1'b0) begin errors++; $display("FAIL straddle_flush: %b, required 0", insnValid); end
    pc_e = pc_norm(7'd3);
    for (int c = 0; c < 200 && got < 2; c++) begin
      @(negedge clock);
      insnAccept = 1'b1;
      if (insnValid) begin
        model_insn(pc_e, code_e, comp_e, nxt_e);
        checks++;
        if (insnPc !== pc_e || insnCode !== code_e || insnIsCompressed !== comp_e) begin
          errors++;
          $display("FAIL straddle: pc %h code %h c %b, required pc %h code %h c %b",
                   insnPc, insnCode, insnIsCompressed, pc_e, code_e, comp_e);
        end
        pc_e = nxt_e;
        got++;
      end
    end
    insnAccept = 1'b0;
    checks++;
    if (got != 2) begin errors++; $display("FAIL straddle_timeout: got %0d, required 2", got); end
  endtask

  task automatic test_redirect_discard();
    logic [AS:0] pc_e, nxt_e;
    logic [31:0] code_e;
    logic        comp_e;
    int got = 0;
    int c;
    bit stale = 0;
    bit seen = 0;
    dly_min = 3;
    dly_max = 3;
    do_redirect(7'd40);
    for (c = 0; c < 50 && !memStrobe; c++) @(negedge clock);
    checks++;
    if (!memStrobe) begin errors++; $display("FAIL discard_start: strobe %b, required 1", memStrobe); end
    do_redirect(7'd20);
    for (c = 0; c < 60 && ready_cnt < snap_ready + 2; c++) begin
      if (insnValid) stale = 1;
      @(negedge clock);
    end
    checks++;
    if (stale) begin errors++; $display("FAIL discard_stale: insnValid 1 before refetch, required 0"); end
    seen = start_addr_q.size() > snap_q;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL discard_refetch: %0d new accesses, required >0", start_addr_q.size() - snap_q);
    end else begin
      checks++;
      if (start_addr_q[snap_q] !== 6'd10) begin
        errors++;
        $display("FAIL discard_addr: %h, required %h", start_addr_q[snap_q], 6'd10);
      end
    end
    pc_e = pc_norm(7'd20);
    for (c = 0; c < 200 && got < 2; c++) begin
      @(negedge clock);
      insnAccept = 1'b1;
      if (insnValid) begin
        model_insn(pc_e, code_e, comp_e, nxt_e);
        checks++;
        if (insnPc !== pc_e || insnCode !== code_e || insnIsCompressed !== comp_e) begin
          errors++;
          $display("FAIL discard_insn: pc %h code %h, required pc %h code %h",
                   insnPc, insnCode, pc_e, code_e);
        end
        pc_e = nxt_e;
        got++;
      end
    end
    insnAccept = 1'b0;
    checks++;
    if (got != 2) begin errors++; $display("FAIL discard_timeout: got %0d, required 2", got); end
  endtask

  task automatic test_back_to_back();
    logic [AS:0] pc_e, nxt_e;
    logic [31:0] code_e;
    logic        comp_e;
    int k_burst;
    int got = 0;
    dly_min = 0;
    dly_max = 1;
    for (int w = 32; w < 40; w++) begin
      mem[w] = {$urandom_range(16'hFFFF, 0)} & 32'hFFFC_FFFC;
      mem[w] = mem[w] | {14'h0, 2'($urandom_range(2, 0)), 14'h0, 2'($urandom_range(2, 0))};
    end
    do_redirect(7'd64);
    repeat (30) @(negedge clock);
    checks += 4;
    if (memStrobe !== 1'b0) begin errors++; $display("FAIL full_strobe: %b, required 0", memStrobe); end
    if (insnValid !== 1'b1) begin errors++; $display("FAIL full_valid: %b, required 1", insnValid); end
    if (insnPc !== 7'd64) begin errors++; $display("FAIL full_pc: %h, required %h", insnPc, 7'd64); end
    if (start_addr_q.size() - snap_q != QP / 2) begin
      errors++;
      $display("FAIL full_fetches: %0d, required %0d", start_addr_q.size() - snap_q, QP / 2);
    end
    // A full queue of parcels must drain one instruction per cycle.
    k_burst = RVC ? QP : QP / 2;
    pc_e = 7'd64;
    for (int k = 0; k < k_burst + 6; k++) begin
      if (k < k_burst) begin
        @(negedge clock);
        checks++;
        if (insnValid !== 1'b1) begin
          errors++;
          $display("FAIL burst_valid[%0d]: %b, required 1", k, insnValid);
        end
      end else begin
        for (int c = 0; c < 50 && !insnValid; c++) @(negedge clock);
      end
      insnAccept = 1'b1;
      if (insnValid) begin
        model_insn(pc_e, code_e, comp_e, nxt_e);
        checks++;
        if (insnPc !== pc_e || insnCode !== code_e || insnIsCompressed !== comp_e) begin
          errors++;
          $display("FAIL burst_insn[%0d]: pc %h code %h c %b, required pc %h code %h c %b", k,
                   insnPc, insnCode, insnIsCompressed, pc_e, code_e, comp_e);
        end
        pc_e = nxt_e;
        got++;
      end
      @(posedge clock);
      #1;
      insnAccept = 1'b0;
    end
    checks++;
    if (got != k_burst + 6) begin
      errors++; $display("FAIL burst_count: got %0d, required %0d", got, k_burst + 6);
    end
  endtask

  task automatic test_wrap();
    logic [AS:0] pc_e, nxt_e;
    logic [31:0] code_e;
    logic        comp_e;
    int got = 0;
    int c;
    mem[63] = $urandom;
    mem[0]  = $urandom;
    mem[1]  = $urandom;
    do_redirect(7'd126);
    pc_e = 7'd126;
    for (c = 0; c < 200 && got < 3; c++) begin
      @(negedge clock);
      insnAccept = 1'b1;
      if (insnValid) begin
        model_insn(pc_e, code_e, comp_e, nxt_e);
        checks++;
        if (insnPc !== pc_e || insnCode !== code_e || insnIsCompressed !== comp_e) begin
          errors++;
          $display("FAIL wrap_insn: pc %h code %h, required pc %h code %h",
                   insnPc, insnCode, pc_e, code_e);
        end
        pc_e = nxt_e;
        got++;
      end
    end
    insnAccept = 1'b0;
    checks++;
    if (got != 3) begin errors++; $display("FAIL wrap_timeout: got %0d, required 3", got); end
    checks++;
    if (start_addr_q.size() < snap_q + 2) begin
      errors++; $display("FAIL wrap_fetches: %0d, required >=2", start_addr_q.size() - snap_q);
    end else begin
      checks += 2;
      if (start_addr_q[snap_q] !== 6'd63) begin
        errors++; $display("FAIL wrap_addr0: %h, required 3f", start_addr_q[snap_q]);
      end
      if (start_addr_q[snap_q + 1] !== 6'd0) begin
        errors++; $display("FAIL wrap_addr1: %h, required 00", start_addr_q[snap_q + 1]);
      end
    end
    // Redirect and accept in the same cycle: the redirect must win.
    for (c = 0; c < 50 && !insnValid; c++) @(negedge clock);
    insnAccept = 1'b1;
    redirectValid = 1'b1;
    redirectPc = 7'd11;
    @(negedge clock);
    insnAccept = 1'b0;
    redirectValid = 1'b0;
    checks += 2;
    if (insnValid !== 1'b0) begin errors++; $display("FAIL redir_acc_valid: %b, required 0", insnValid); end
    if (insnPc !== pc_norm(7'd11)) begin
      errors++; $display("FAIL redir_acc_pc: %h, required %h", insnPc, pc_norm(7'd11));
    end
    pc_e = pc_norm(7'd11);
    got = 0;
    for (c = 0; c < 200 && got < 2; c++) begin
      @(negedge clock);
      insnAccept = 1'b1;
      if (insnValid) begin
        model_insn(pc_e, code_e, comp_e, nxt_e);
        checks++;
        if (insnPc !== pc_e || insnCode !== code_e || insnIsCompressed !== comp_e) begin
          errors++;
          $display("FAIL redir_acc_insn: pc %h code %h, required pc %h code %h",
                   insnPc, insnCode, pc_e, code_e);
        end
        pc_e = nxt_e;
        got++;
      end
    end
    insnAccept = 1'b0;
    checks++;
    if (got != 2) begin errors++; $display("FAIL redir_acc_timeout: got %0d, required 2", got); end
  endtask

  task automatic test_random();
    logic [AS:0] pc_e, nxt_e, start;
    logic [31:0] code_e;
    logic        comp_e;
    int got;
    dly_min = 0;
    dly_max = 2;
    for (int w = 0; w < 64; w++) mem[w] = $urandom;
    for (int r = 0; r < 8; r++) begin
      start = 7'($urandom_range(127, 0));
      do_redirect(start);
      pc_e = pc_norm(start);
      got = 0;
      for (int c = 0; c < 300 && got < 10; c++) begin
        @(negedge clock);
        insnAccept = ($urandom_range(99, 0) < 60);
        if (insnValid && insnAccept) begin
          model_insn(pc_e, code_e, comp_e, nxt_e);
          checks++;
          if (insnPc !== pc_e || insnCode !== code_e || insnIsCompressed !== comp_e) begin
            errors++;
            $display("FAIL random[%0d]: pc %h code %h c %b, required pc %h code %h c %b", r,
                     insnPc, insnCode, insnIsCompressed, pc_e, code_e, comp_e);
          end
          pc_e = nxt_e;
          got++;
        end
      end
      insnAccept = 1'b0;
      checks++;
      if (got != 10) begin errors++; $display("FAIL random_timeout[%0d]: got %0d, required 10", r, got); end
    end
  endtask

  initial begin
    for (int w = 0; w < 64; w++) mem[w] = $urandom;
    mem[0] = 32'h00A0_0093;
    mem[1] = 32'h4505_4501;
    dly_min = 0;
    dly_max = 2;
    test_reset();
    test_example();
    test_straddle();
    test_redirect_discard();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
